modulator_sequencer: RTL and testbench
======================================

MODULATOR_SEQUENCER -- requirements
Module: modulator_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named clk and reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  level, sampled each cycle; begins a sequence from IDLE.
REQ-005 stop  input  1  level; aborts any sequence.
REQ-006 loop_en  input  1  1 = restart at step 0 after step 3.
REQ-007 cfg_we  input  1  table write strobe.
REQ-008 cfg_addr  input  2  table entry index 0..3.
REQ-009 cfg_div  input  8  half-period of out in clk cycles (0 = skip entry).
REQ-010 cfg_len  input  8  number of full out periods for the entry (0 = skip entry).
REQ-011 out  output  1  modulated clock, registered.
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 step  output  2  index of the active or next-loaded entry.
REQ-014 done  output  1  single-cycle pulse at normal completion.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: out=0, busy=0; start=1 and stop=0 -> LOAD with step=0 and pass_played=0.
REQ-017 LOAD (1 cycle): if table[step].div==0 or .len==0, the entry is skipped and the step-advance rule (REQ-020) applies directly; else half-counter=div-1, period-counter=len, pass_played=1, -> RUN.
REQ-018 RUN: half-counter decrements each cycle; at 0, out toggles and half-counter reloads div-1; out period = 2*div cycles, 50% duty, first rise div cycles after RUN entry.
REQ-019 RUN: each 1->0 toggle of out decrements period-counter; when it reaches 0, the step-advance rule applies in the same cycle (out stays 0).
REQ-020 Step advance: step<3 -> step+1, LOAD; step==3 and loop_en=1 and pass_played=1 -> step=0, pass_played=0, LOAD; otherwise -> DONE.
REQ-021 DONE (1 cycle): done=1, out=0, busy=0, -> IDLE; step holds its last value until the next start.
REQ-022 stop=1 in any state -> IDLE next cycle, out=0, done not pulsed; stop has priority over start.
REQ-023 start while busy SHALL be ignored.
REQ-024 cfg_we SHALL write table[cfg_addr] only when busy=0; writes while busy SHALL be dropped.
REQ-025 loop_en SHALL be sampled only at the step-3 advance.
REQ-026 div=1 SHALL give out period 2 cycles; div=255, len=255 SHALL run 130050 cycles without counter overflow.

Reset
REQ-027 reset SHALL force IDLE, out=0, busy=0, done=0, step=0, pass_played=0, counters=0, and all table entries div=0, len=0, independent of clk.
REQ-028 reset asserted mid-RUN SHALL drop out to 0 immediately; no done pulse on release.

Structure
REQ-029 Shared package modulator_pkg SHALL hold NUM_STEPS=4, DIV_W=8, LEN_W=8 and the FSM state encoding.
REQ-030 Table storage SHALL be one sub-module, modulator_step_table (4x16-bit register file, one write port, one async read port).

Verification (cycle 0 = edge sampling start)
REQ-031 Entry0 div=2 len=3, others 0, start pulse -> LOAD cycle 1, out=1 in cycles 4-5, 8-9, 12-13, skip LOADs 14-16, done=1 in cycle 17 only.
REQ-032 All entries 0, loop_en=1, start -> four skip LOADs, then DONE; no infinite loop, out stays 0.
REQ-033 Entry0 div=1 len=2, loop_en=1 -> out toggles every cycle and repeats indefinitely, step returns to 0 each pass; stop -> out=0, busy=0 next cycle, no done.
REQ-034 cfg_we to entry1 during RUN -> table unchanged; same write with busy=0 -> takes effect on next start.
REQ-035 reset asserted mid-RUN with out=1 -> out=0 before next clk edge; after release, IDLE with table cleared.
REQ-036 start held high through DONE -> new sequence begins from LOAD the cycle after IDLE is re-entered; start during RUN has no effect.

Source files
------------

// File: rtl/modulator_pkg.sv
// modulator_pkg: shared widths, state encoding and table entry type for the modulator sequencer
package modulator_pkg;
  localparam int NUM_STEPS = 4;
  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int DIV_W = 8;
  localparam int LEN_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [LEN_W-1:0] len;
  } entry_t;
endpackage

// File: rtl/modulator_step_table.sv
// modulator_step_table: 4-entry {div,len} register file, one write port, async read
module modulator_step_table
  import modulator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [STEP_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [STEP_W-1:0] raddr,
  output entry_t            rdata
);
  entry_t mem [NUM_STEPS];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/modulator_sequencer.sv
// modulator_sequencer: plays a table of (half-period, period count) entries as a modulated clock
module modulator_sequencer
  import modulator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              out,
  output logic              busy,
  output logic [STEP_W-1:0] step,
  output logic              done
);
  logic [1:0] state;
  logic pass_played;
  logic [DIV_W-1:0] half;
  logic [LEN_W-1:0] periods;
  entry_t cur;
  logic skip, last, wrap;
  logic [1:0] adv_state;
  logic [STEP_W-1:0] adv_step;
  modulator_step_table u_table (
    .clk(clk),
    .reset(reset),
    .we(cfg_we && !busy),
    .waddr(cfg_addr),
    .wdata({cfg_div, cfg_len}),
    .raddr(step),
    .rdata(cur)
  );
  assign busy = state == ST_LOAD || state == ST_RUN;
  assign done = state == ST_DONE;
  assign skip = cur.div == '0 || cur.len == '0;
  assign last = step == STEP_W'(NUM_STEPS - 1);
  // pass_played stops an all-skip table from looping forever
  assign wrap = last && loop_en && pass_played;
  assign adv_state = last && !wrap ? ST_DONE : ST_LOAD;
  assign adv_step = wrap ? '0 : last ? step : step + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      out <= 1'b0;
      step <= '0;
      pass_played <= 1'b0;
      half <= '0;
      periods <= '0;
    end else if (stop) begin
      state <= ST_IDLE;
      out <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        state <= ST_LOAD;
        step <= '0;
        pass_played <= 1'b0;
      end
    end else if (state == ST_LOAD) begin
      if (skip) begin
        state <= adv_state;
        step <= adv_step;
        if (wrap) pass_played <= 1'b0;
      end else begin
        half <= cur.div - 1'b1;
        periods <= cur.len;
        pass_played <= 1'b1;
        state <= ST_RUN;
      end
    end else if (state == ST_RUN) begin
      half <= half == '0 ? cur.div - 1'b1 : half - 1'b1;
      if (half == '0) begin
        out <= ~out;
        if (out) begin
          periods <= periods - 1'b1;
          if (periods == LEN_W'(1)) begin
            state <= adv_state;
            step <= adv_step;
            if (wrap) pass_played <= 1'b0;
          end
        end
      end
    end else state <= ST_IDLE;
endmodule

// File: tb/tb_modulator_sequencer.sv
// tb_modulator_sequencer: directed and random checks against a trace-based reference model
module tb_modulator_sequencer;
  logic clk = 1'b0;
  logic reset, start, stop, loop_en, cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_div, cfg_len;
  logic out, busy, done;
  logic [1:0] step;
  int tests = 0, fails = 0;
  int m_mode = 0, m_step = 0, c;
  bit m_pass = 0;
  bit q[$];
  int tdiv[4], tlen[4];
  logic [63:0] ov, dv, bv;
  logic seen;

  modulator_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div), .cfg_len(cfg_len),
    .out(out), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: each entry expands into its full output trace (LOAD cycle + 2*div*len RUN cycles)
  function automatic void load_entry();
    int d = tdiv[m_step];
    int l = tlen[m_step];
    q.push_back(1'b0);
    if (d != 0 && l != 0) begin
      m_pass = 1'b1;
      for (int k = 0; k < 2 * d * l; k++) q.push_back(((k / d) % 2) == 1);
    end
  endfunction

  function automatic void advance();
    if (m_step < 3) begin
      m_step++;
      load_entry();
    end else if (loop_en && m_pass) begin
      m_step = 0;
      m_pass = 1'b0;
      load_entry();
    end else m_mode = 2;
  endfunction

  function automatic bit exp_out();
    return (m_mode == 1 && q.size() > 0) ? q[0] : 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0;
      m_step = 0;
      m_pass = 1'b0;
      q.delete();
      for (int i = 0; i < 4; i++) begin
        tdiv[i] = 0;
        tlen[i] = 0;
      end
    end else begin
      if (cfg_we && m_mode != 1) begin
        tdiv[cfg_addr] = cfg_div;
        tlen[cfg_addr] = cfg_len;
      end
      if (stop) begin
        m_mode = 0;
        q.delete();
      end else if (m_mode == 0) begin
        if (start) begin
          m_mode = 1;
          m_step = 0;
          m_pass = 1'b0;
          load_entry();
        end
      end else if (m_mode == 2) m_mode = 0;
      else begin
        void'(q.pop_front());
        if (q.size() == 0) advance();
      end
    end
  end

  always @(negedge clk) begin
    check("out", out, exp_out());
    check("busy", busy, m_mode == 1);
    check("done", done, m_mode == 2);
    check("step", step, m_step);
  end

  task automatic run(input int n, input bit hold, input int we_at,
                     output logic [63:0] o, output logic [63:0] d, output logic [63:0] b);
    o = '0;
    d = '0;
    b = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k < 64) begin
        o[k] = out;
        d[k] = done;
        b[k] = busy;
      end
      start = hold || k == 0;
      cfg_we = k == we_at;
      cfg_addr = 2'd1;
      cfg_div = 8'd3;
      cfg_len = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int a, input int d, input int l);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 2'(a);
    cfg_div = 8'(d);
    cfg_len = 8'(l);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic stop_seq();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_div = '0;
    cfg_len = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", step, 0);
    loop_en = 1'b1;
    run(8, 0, -1, ov, dv, bv);
    check("empty_done", dv, 64'h20);
    check("empty_out", ov, 0);
    check("empty_busy", bv, 64'h1e);
    loop_en = 1'b0;
    cfg(0, 2, 3);
    run(20, 0, -1, ov, dv, bv);
    check("seq_out", ov, 64'h3330);
    check("seq_done", dv, 64'h20000);
    check("seq_busy", bv, 64'h1fffe);
    run(20, 0, 5, ov, dv, bv);
    check("busy_write_dropped", dv, 64'h20000);
    cfg(1, 3, 1);
    run(26, 0, -1, ov, dv, bv);
    check("idle_write_done", dv, 64'h800000);
    check("idle_write_out", ov, 64'h1c3330);
    cfg(1, 0, 0);
    run(22, 1, -1, ov, dv, bv);
    check("hold_busy", bv, 64'h39fffe);
    check("hold_done", dv, 64'h20000);
    stop_seq();
    cfg(0, 1, 2);
    loop_en = 1'b1;
    run(20, 0, -1, ov, dv, bv);
    check("loop_out", ov, 64'h82828);
    check("loop_busy", bv, 64'hffffe);
    stop_seq();
    check("stop_out", out, 0);
    check("stop_busy", busy, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("stop_no_done", seen, 0);
    loop_en = 1'b0;
    cfg(0, 2, 3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (out !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("rst_wait_out_high", out, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    run(8, 0, -1, ov, dv, bv);
    check("cleared_done", dv, 64'h20);
    check("cleared_out", ov, 0);
    cfg(0, 255, 2);
    @(negedge clk);
    start = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      c++;
    end while (done !== 1'b1 && c < 2000);
    check("div255_done_cycle", c, 1025);
    repeat (4000) begin
      @(negedge clk);
      start = $urandom_range(7) == 0;
      stop = $urandom_range(39) == 0;
      loop_en = 1'($urandom_range(1));
      cfg_we = $urandom_range(3) == 0;
      cfg_addr = 2'($urandom_range(3));
      cfg_div = 8'($urandom_range(4));
      cfg_len = 8'($urandom_range(3));
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
